// File: rtl/line_window_3x3.sv
// line_window_3x3 -- 3x3 sliding-window generator over a raster pixel stream.
// Two line buffers hold the previous two rows. A 3x3 window register shifts one
// column per accepted pixel. A window is only presented once it is fully inside
// the frame (row >= 2, col >= 2), so no padding is needed and no window wraps
// across a row edge. There is a single output slot with valid/ready handshaking.
// Optional feature macro: LW_FRAME_DONE_EN adds a one-cycle frame_done pulse,
// coincident with the last window of each frame.
module line_window_3x3 #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_pixel,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [71:0] out_window
`ifdef LW_FRAME_DONE_EN
  ,
  output logic        frame_done
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  // Position of the next pixel to be accepted.
  logic [CW-1:0] col_r;
  logic [RW-1:0] row_r;

  // lb0 holds row-1 and lb1 holds row-2, both indexed by column.
  logic [7:0]    lb0_r [IMG_W];
  logic [7:0]    lb1_r [IMG_W];

  logic [71:0]   win_r;
  logic          out_valid_r;

  logic          accept_s;
  logic          col_last_s;
  logic          row_last_s;
  logic          qualify_s;
  logic [7:0]    lb0_rd_s;
  logic [7:0]    lb1_rd_s;
  logic [71:0]   win_next_s;

  // A new pixel can enter whenever the output slot is empty or is being drained.
  assign in_ready   = !out_valid_r || out_ready;
  assign out_valid  = out_valid_r;
  assign out_window = win_r;

  // Handshake decode and window-position qualification for the current pixel.
  always_comb begin
    accept_s   = in_valid && in_ready;
    col_last_s = (col_r == COL_LAST);
    row_last_s = (row_r == ROW_LAST);
    qualify_s  = (row_r >= ROW_TWO) && (col_r >= COL_TWO);
    lb0_rd_s   = lb0_r[col_r];
    lb1_rd_s   = lb1_r[col_r];
  end

  // Next window: shift each row toward c=0 and load the new column from the
  // line buffers' pre-write contents plus the incoming pixel.
  always_comb begin
    win_next_s = win_r;
    for (int r = 0; r < 3; r++) begin
      win_next_s[(r*3+0)*8 +: 8] = win_r[(r*3+1)*8 +: 8];
      win_next_s[(r*3+1)*8 +: 8] = win_r[(r*3+2)*8 +: 8];
    end
    win_next_s[(0*3+2)*8 +: 8] = lb1_rd_s;
    win_next_s[(1*3+2)*8 +: 8] = lb0_rd_s;
    win_next_s[(2*3+2)*8 +: 8] = in_pixel;
  end

  // Raster position counters; wrap at row end and at frame end.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_r <= '0;
      row_r <= '0;
    end else if (accept_s) begin
      if (col_last_s) begin
        col_r <= '0;
        if (row_last_s) begin
          row_r <= '0;
        end else begin
          row_r <= row_r + RW'(1);
        end
      end else begin
        col_r <= col_r + CW'(1);
      end
    end
  end

  // Line buffer update: the old row-1 value moves down to row-2 as the new pixel
  // lands in row-1. Contents are not reset; stale data is masked by qualification.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      lb1_r[col_r] <= lb0_rd_s;
      lb0_r[col_r] <= in_pixel;
    end
  end

  // Window register and the single output slot's valid flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_r       <= 72'd0;
      out_valid_r <= 1'b0;
    end else begin
      if (accept_s) begin
        win_r <= win_next_s;
      end
      if (accept_s && qualify_s) begin
        out_valid_r <= 1'b1;
      end else if (out_ready) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

`ifdef LW_FRAME_DONE_EN
  logic frame_done_r;
  assign frame_done = frame_done_r;

  // One-cycle pulse after the last pixel of the frame is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= accept_s && col_last_s && row_last_s;
    end
  end
`endif

endmodule

// File: tb/tb_line_window_3x3.sv
// Directed self-checking bench for line_window_3x3 with a 4x4 image.
// When LW_FRAME_DONE_EN is defined, the frame_done pulse is also checked.
module tb_line_window_3x3;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_pixel;
  logic        out_valid;
  logic        out_ready;
  logic [71:0] out_window;
`ifdef LW_FRAME_DONE_EN
  logic        frame_done;
`endif

  int n_cmp;
  int n_bad;
  int fd_n;
  logic [71:0] win_q [$];
  logic [71:0] w_exp [4];

  line_window_3x3 #(.IMG_W(4), .IMG_H(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pixel   (in_pixel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_window (out_window)
`ifdef LW_FRAME_DONE_EN
    ,
    .frame_done (frame_done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [71:0] pack9(input int e0, input int e1, input int e2,
                                        input int e3, input int e4, input int e5,
                                        input int e6, input int e7, input int e8);
    logic [71:0] v;
    v = {8'(e8), 8'(e7), 8'(e6), 8'(e5), 8'(e4), 8'(e3), 8'(e2), 8'(e1), 8'(e0)};
    return v;
  endfunction

  function automatic logic [71:0] add_base(input logic [71:0] w, input int base);
    logic [71:0] v;
    for (int k = 0; k < 9; k++) v[k*8 +: 8] = w[k*8 +: 8] + 8'(base);
    return v;
  endfunction

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_out_valid",  {71'd0, out_valid}, 72'd0);
    check("rst_out_window", out_window, 72'd0);
    check("rst_in_ready",   {71'd0, in_ready}, 72'd1);
  endtask

  // Drive pixels first..last of a frame with offset base, collecting windows.
  task automatic stream(input int base, input int first, input int last, input bit bubble);
    int p;
    int cyc;
    bit acc;
    p   = first;
    cyc = 0;
    while (p <= last && cyc < 200) begin
      out_ready = 1'b1;
      in_valid  = bubble ? (cyc % 2 == 0) : 1'b1;
      in_pixel  = 8'(base + p);
      #1;
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) p++;
      if (out_valid) begin
        check("valid_after_accept", {71'd0, out_valid}, {71'd0, acc});
        win_q.push_back(out_window);
      end
`ifdef LW_FRAME_DONE_EN
      if (frame_done) begin
        fd_n++;
        check("fd_valid",  {71'd0, out_valid}, 72'd1);
        check("fd_window", out_window, add_base(w_exp[3], base));
      end
`endif
      cyc++;
    end
    if (p <= last) check("stream_timeout", 72'(p), 72'(last + 1));
    in_valid = 1'b0;
  endtask

  task automatic idle_check();
    @(posedge clk); #1;
    check("drain_out_valid", {71'd0, out_valid}, 72'd0);
  endtask

  task automatic check_frame(input string tag, input int off, input int base);
    for (int k = 0; k < 4; k++) check(tag, win_q[off + k], add_base(w_exp[k], base));
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    fd_n      = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_pixel  = 8'd0;
    out_ready = 1'b1;
    w_exp[0] = pack9(0, 1, 2, 4, 5, 6, 8, 9, 10);
    w_exp[1] = pack9(1, 2, 3, 5, 6, 7, 9, 10, 11);
    w_exp[2] = pack9(4, 5, 6, 8, 9, 10, 12, 13, 14);
    w_exp[3] = pack9(5, 6, 7, 9, 10, 11, 13, 14, 15);
    @(posedge clk); #1;

    // Continuous streaming: exactly 4 windows.
    do_reset();
    win_q.delete();
    stream(0, 0, 15, 1'b0);
    idle_check();
    check("stream_count", 72'(win_q.size()), 72'd4);
    if (win_q.size() == 4) check_frame("stream_win", 0, 0);

    // Backpressure after the first window.
    do_reset();
    win_q.delete();
    stream(0, 0, 10, 1'b0);
    check("bp_first_count", 72'(win_q.size()), 72'd1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_pixel  = 8'd11;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_in_ready",  {71'd0, in_ready}, 72'd0);
      check("bp_out_valid", {71'd0, out_valid}, 72'd1);
      check("bp_hold_win",  out_window, w_exp[0]);
    end
    stream(0, 11, 15, 1'b0);
    idle_check();
    check("bp_count", 72'(win_q.size()), 72'd4);
    if (win_q.size() == 4) check_frame("bp_win", 0, 0);

    // Bubbles on in_valid.
    do_reset();
    win_q.delete();
    stream(0, 0, 15, 1'b1);
    idle_check();
    check("bub_count", 72'(win_q.size()), 72'd4);
    if (win_q.size() == 4) check_frame("bub_win", 0, 0);

    // Two back-to-back frames.
    do_reset();
    win_q.delete();
    stream(0, 0, 15, 1'b0);
    stream(100, 0, 15, 1'b0);
    idle_check();
    check("b2b_count", 72'(win_q.size()), 72'd8);
    if (win_q.size() == 8) begin
      check_frame("b2b_f1", 0, 0);
      check_frame("b2b_f2", 4, 100);
    end

    // Reset mid-frame, then restart.
    do_reset();
    win_q.delete();
    stream(0, 0, 9, 1'b0);
    check("mid_no_win", 72'(win_q.size()), 72'd0);
    do_reset();
    stream(0, 0, 15, 1'b0);
    idle_check();
    check("mid_count", 72'(win_q.size()), 72'd4);
    if (win_q.size() == 4) check_frame("mid_win", 0, 0);

`ifdef LW_FRAME_DONE_EN
    check("fd_total", 72'(fd_n), 72'd6);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
